free_list: RTL

- Physical-register free list for the rename stage.
- Supplies up to 3 new physical destination tags per cycle to rename.
- Reclaims up to 2 old physical tags per cycle from ROB retirement (the ROB's `rd1_free`/`rd2_free` + valid outputs).
- Implemented as a circular FIFO of 6-bit tags with all-or-nothing allocation.

---
 rtl/free_list.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//
// Physical-register free list for the rename stage. Idle physical tags sit in
// a circular FIFO. Rename can take up to three tags per cycle, and allocation
// is all-or-nothing. Retirement can return up to two tags per cycle.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   alloc_req1..3              rename slots that need a new destination tag
//   alloc_grant                every requested tag is available this cycle
//   alloc_tag1..3              tag offered to each slot (combinational)
//   free_valid1/2, free_tag1/2 tags returned by retirement, port 1 first
//   free_count, empty          occupancy of the list
//   overflow_err               sticky: a free was dropped because list was full
//   double_free_err            sticky: a duplicate free was dropped
//                              (only with FREE_LIST_DOUBLE_FREE_CHECK_EN)
//
// Build option
//   FREE_LIST_DOUBLE_FREE_CHECK_EN adds a membership bitmap. Duplicate frees
//   are rejected and reported on double_free_err. When the macro is not
//   defined, duplicates are enqueued unchecked.
// -----------------------------------------------------------------------------
module free_list #(
  parameter int PREG_W    = 6,
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req1,
  input  logic              alloc_req2,
  input  logic              alloc_req3,
  output logic              alloc_grant,
  output logic [PREG_W-1:0] alloc_tag1,
  output logic [PREG_W-1:0] alloc_tag2,
  output logic [PREG_W-1:0] alloc_tag3,
  input  logic              free_valid1,
  input  logic [PREG_W-1:0] free_tag1,
  input  logic              free_valid2,
  input  logic [PREG_W-1:0] free_tag2,
  output logic [PREG_W-1:0] free_count,
  output logic              empty,
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  output logic              double_free_err,
`endif
  output logic              overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_P = (PTR_W+1)'(DEPTH);
  localparam logic [PREG_W-1:0] DEPTH_C = PREG_W'(DEPTH);

  logic [PREG_W-1:0] fifo_q [DEPTH];
  logic [PREG_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PREG_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [1:0] n_req;
  logic [1:0] n_grant;
  logic [1:0] off2;
  logic [1:0] off3;
  logic       take1;
  logic       take2;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_PREGS-1:0] in_list_q, in_list_d;
  logic                 dfe_q, dfe_d;
`endif

  // Pointer advance modulo DEPTH. DEPTH does not need to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PTR_W-1:0];
  endfunction

  // Requesting slots are packed in slot order. Each slot's offset from head is
  // the number of lower-index slots that are also requesting.
  always_comb begin
    n_req = {1'b0, alloc_req1} + {1'b0, alloc_req2} + {1'b0, alloc_req3};
    off2  = {1'b0, alloc_req1};
    off3  = {1'b0, alloc_req1} + {1'b0, alloc_req2};
    alloc_grant = (n_req != 2'd0) && (count_q >= {{(PREG_W-2){1'b0}}, n_req});
    alloc_tag1  = fifo_q[head_q];
    alloc_tag2  = fifo_q[ptr_add(head_q, off2)];
    alloc_tag3  = fifo_q[ptr_add(head_q, off3)];
  end

  assign free_count   = count_q;
  assign empty        = (count_q == '0);
  assign overflow_err = overflow_q;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  assign double_free_err = dfe_q;
`endif

  // Next-state logic. The allocation is applied first. The frees are then
  // processed in port order against the post-allocation occupancy. A tag freed
  // this cycle is therefore never handed out in the same cycle.
  always_comb begin
    fifo_d     = fifo_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    n_grant    = alloc_grant ? n_req : 2'd0;
    head_d     = ptr_add(head_q, n_grant);
    count_d    = count_q - {{(PREG_W-2){1'b0}}, n_grant};
    take1      = free_valid1 && (free_tag1 != '0);
    take2      = free_valid2 && (free_tag2 != '0);
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    in_list_d = in_list_q;
    dfe_d     = dfe_q;
    if (alloc_grant && alloc_req1) in_list_d[alloc_tag1] = 1'b0;
    if (alloc_grant && alloc_req2) in_list_d[alloc_tag2] = 1'b0;
    if (alloc_grant && alloc_req3) in_list_d[alloc_tag3] = 1'b0;
    if (take1 && in_list_d[free_tag1]) begin
      take1 = 1'b0;
      dfe_d = 1'b1;
    end
`endif
    if (take1) begin
      if (count_d == DEPTH_C) begin
        overflow_d = 1'b1;
      end else begin
        fifo_d[tail_d] = free_tag1;
        tail_d         = ptr_add(tail_d, 2'd1);
        count_d        = count_d + {{(PREG_W-1){1'b0}}, 1'b1};
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
        in_list_d[free_tag1] = 1'b1;
`endif
      end
    end
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    // Port 2 freeing the same tag as port 1 counts as a duplicate, even if
    // port 1 itself was dropped because the list was full.
    if (take2 && (in_list_d[free_tag2] ||
                  (free_valid1 && (free_tag1 == free_tag2)))) begin
      take2 = 1'b0;
      dfe_d = 1'b1;
    end
`endif
    if (take2) begin
      if (count_d == DEPTH_C) begin
        overflow_d = 1'b1;
      end else begin
        fifo_d[tail_d] = free_tag2;
        tail_d         = ptr_add(tail_d, 2'd1);
        count_d        = count_d + {{(PREG_W-1){1'b0}}, 1'b1};
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
        in_list_d[free_tag2] = 1'b1;
`endif
      end
    end
  end

  // After reset, the list holds every tag that is not mapped to an
  // architectural register. Those tags are NUM_AREGS up to NUM_PREGS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= PREG_W'(NUM_AREGS + i);
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= DEPTH_C;
      overflow_q <= 1'b0;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      for (int i = 0; i < NUM_PREGS; i++) in_list_q[i] <= (i >= NUM_AREGS);
      dfe_q <= 1'b0;
`endif
    end else begin
      fifo_q     <= fifo_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      in_list_q <= in_list_d;
      dfe_q     <= dfe_d;
`endif
    end
  end

endmodule
